// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared encodings, defaults and FSM state type for the memory request interface
package mem_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reserved size code 11 behaves as a word, so it needs word alignment too
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian lane steering for reads and writes
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_aligned,
    output logic [31:0] wdata_merged,
    output logic [3:0]  byte_en
);

    // Byte offset 0 is the most significant lane; byte_en[3] covers bits [31:24]
    always_comb begin
        rdata_aligned = word;
        wdata_merged  = wdata;
        byte_en       = 4'b1111;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    rdata_aligned = {24'h0, word[31:24]};
                    2'd1:    rdata_aligned = {24'h0, word[23:16]};
                    2'd2:    rdata_aligned = {24'h0, word[15:8]};
                    default: rdata_aligned = {24'h0, word[7:0]};
                endcase
                wdata_merged = {4{wdata[7:0]}};
                byte_en      = 4'b1000 >> offset;
            end
            SZ_HALF: begin
                rdata_aligned = offset[1] ? {16'h0, word[15:0]} : {16'h0, word[31:16]};
                wdata_merged  = {2{wdata[15:0]}};
                byte_en       = offset[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                rdata_aligned = word;
                wdata_merged  = wdata;
                byte_en       = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/insn_mem_responder.sv
// rtl/insn_mem_responder.sv - word-organised RAM window serving one request at a time with fixed latency
module insn_mem_responder
    import mem_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        read_write,
    input  logic [31:0] address_in,
    input  logic [1:0]  access_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        valid,
    output logic        error
);

    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT     = 4'(LATENCY - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_rw;
    logic [31:0]      r_wdata;
    logic [31:0]      r_data_out;
    logic             r_busy;
    logic             r_valid;
    logic             r_error;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic [31:0]      w_off;
    logic             w_in_range;
    logic             w_misaligned;
    logic [31:0]      w_word;
    logic [31:0]      w_rdata;
    logic [31:0]      w_wmerged;
    logic [3:0]       w_byte_en;

    // Lower-bound test first so the subtraction cannot wrap into the window
    assign w_off        = address_in - BASE_ADDR;
    assign w_in_range   = (address_in >= BASE_ADDR) && (w_off < WINDOW_BYTES);
    assign w_misaligned = is_misaligned(access_size, address_in[1:0]);
    assign w_word       = r_mem[r_idx];

    mem_lane_align u_align (
        .offset        (r_off),
        .size          (r_size),
        .word          (w_word),
        .wdata         (r_wdata),
        .rdata_aligned (w_rdata),
        .wdata_merged  (w_wmerged),
        .byte_en       (w_byte_en)
    );

    // Request FSM: accept in IDLE, count down in WAIT, complete in DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_off      <= 2'b00;
            r_size     <= SZ_WORD;
            r_rw       <= RW_READ;
            r_wdata    <= 32'h0;
            r_data_out <= 32'h0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        if (!w_in_range || w_misaligned) begin
                            r_error <= 1'b1;
                        end else begin
                            r_idx   <= w_off[IDX_W+1:2];
                            r_off   <= address_in[1:0];
                            r_size  <= access_size;
                            r_rw    <= read_write;
                            r_wdata <= data_in;
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_INIT;
                            r_state <= (LATENCY == 1) ? ST_DONE : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (r_rw == RW_READ) begin
                        r_data_out <= w_rdata;
                        r_valid    <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM commit happens only on the DONE edge; an async reset leaves DONE before it can fire
    always_ff @(posedge clk) begin
        if (r_state == ST_DONE && r_rw == RW_WRITE) begin
            for (int k = 0; k < 4; k++) begin
                if (w_byte_en[k]) begin
                    r_mem[r_idx][8*k +: 8] <= w_wmerged[8*k +: 8];
                end
            end
        end
    end

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign valid    = r_valid;
    assign error    = r_error;

endmodule

// File: tb/tb_insn_mem_responder.sv
// tb/tb_insn_mem_responder.sv - randomized self-checking bench with a byte-array reference model
module tb_insn_mem_responder;

    localparam logic [31:0] BASE = 32'h8002_0000;
    localparam int          NU   = 3;

    int          lat [NU] = '{1, 3, 4};
    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        en    [NU];
    logic        rw    [NU];
    logic [31:0] addr  [NU];
    logic [1:0]  sz    [NU];
    logic [31:0] din   [NU];
    logic [31:0] dout  [NU];
    logic        busy  [NU];
    logic        valid [NU];
    logic        err   [NU];

    int          n_checks = 0;
    int          n_fail   = 0;
    bit   [31:0] mdl_mem [NU][1024];
    logic [31:0] last_rd [NU];

    always #5 clk = ~clk;

    insn_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .enable(en[0]), .read_write(rw[0]), .address_in(addr[0]),
        .access_size(sz[0]), .data_in(din[0]), .data_out(dout[0]), .busy(busy[0]),
        .valid(valid[0]), .error(err[0]));

    insn_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .reset_n(reset_n), .enable(en[1]), .read_write(rw[1]), .address_in(addr[1]),
        .access_size(sz[1]), .data_in(din[1]), .data_out(dout[1]), .busy(busy[1]),
        .valid(valid[1]), .error(err[1]));

    insn_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .reset_n(reset_n), .enable(en[2]), .read_write(rw[2]), .address_in(addr[2]),
        .access_size(sz[2]), .data_in(din[2]), .data_out(dout[2]), .busy(busy[2]),
        .valid(valid[2]), .error(err[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit req_bad(input logic [31:0] a, input logic [1:0] s);
        longint unsigned la = {32'h0, a};
        longint unsigned lb = {32'h0, BASE};
        if (la < lb || la >= lb + 4096) return 1'b1;
        if (s == 2'd1 && a[0]) return 1'b1;
        if (s >= 2'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_read(input int u, input logic [31:0] a, input logic [1:0] s);
        int       idx = int'((a - BASE) >> 2);
        int       off = int'(a[1:0]);
        bit [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = mdl_mem[u][idx][31-8*k -: 8];
        if (s == 2'd0) return {24'h0, b[off]};
        if (s == 2'd1) return {16'h0, b[off], b[off+1]};
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic void mdl_write(input int u, input logic [31:0] a, input logic [1:0] s,
                                      input logic [31:0] d);
        int       idx = int'((a - BASE) >> 2);
        int       off = int'(a[1:0]);
        bit [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = mdl_mem[u][idx][31-8*k -: 8];
        if (s == 2'd0) b[off] = d[7:0];
        else if (s == 2'd1) begin
            b[off]   = d[15:8];
            b[off+1] = d[7:0];
        end else begin
            b[0] = d[31:24]; b[1] = d[23:16]; b[2] = d[15:8]; b[3] = d[7:0];
        end
        mdl_mem[u][idx] = {b[0], b[1], b[2], b[3]};
    endfunction

    // Issue one request from a negedge and check every cycle until one cycle past completion
    task automatic do_req(input int u, input bit rd, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] d, input bit poke, output logic [31:0] got);
        bit          bad = req_bad(a, s);
        int          L   = lat[u];
        int          n   = bad ? 1 : L + 1;
        logic [31:0] old = last_rd[u];
        logic [31:0] nw  = (!bad && rd) ? mdl_read(u, a, s) : old;
        string       tg  = $sformatf("u%0d_%s_%h_s%0d", u, rd ? "rd" : "wr", a, s);
        en[u] = 1'b1; rw[u] = rd; addr[u] = a; sz[u] = s; din[u] = d;
        for (int j = 0; j <= n; j++) begin
            @(negedge clk);
            if (j == 0) en[u] = 1'b0;
            chk($sformatf("%s_busy_c%0d", tg, j),  32'(busy[u]),  32'(!bad && j < L));
            chk($sformatf("%s_valid_c%0d", tg, j), 32'(valid[u]), 32'(!bad && rd && j == L));
            chk($sformatf("%s_err_c%0d", tg, j),   32'(err[u]),   32'(bad && j == 0));
            chk($sformatf("%s_dout_c%0d", tg, j),  dout[u],       (j >= L) ? nw : old);
            if (poke && j == 1) begin
                en[u] = 1'b1; rw[u] = 1'b1; addr[u] = a + 4; sz[u] = 2'd2;
            end
            if (poke && j == 2) en[u] = 1'b0;
        end
        if (!bad && !rd) mdl_write(u, a, s, d);
        last_rd[u] = nw;
        got = dout[u];
    endtask

    task automatic chk_reset_state(input string tag);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("%s_u%0d_busy", tag, u),  32'(busy[u]),  32'h0);
            chk($sformatf("%s_u%0d_valid", tag, u), 32'(valid[u]), 32'h0);
            chk($sformatf("%s_u%0d_err", tag, u),   32'(err[u]),   32'h0);
            chk($sformatf("%s_u%0d_dout", tag, u),  dout[u],       32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        for (int u = 0; u < NU; u++) begin
            en[u] = 1'b0; rw[u] = 1'b1; addr[u] = 32'h0; sz[u] = 2'd2; din[u] = 32'h0;
            last_rd[u] = 32'h0;
        end
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Word and lane tests at latency 1
        do_req(0, 1'b0, BASE,      2'd2, 32'hDEADBEEF, 1'b0, got);
        do_req(0, 1'b1, BASE,      2'd2, 32'h0,        1'b0, got);
        chk("plan_word_read", got, 32'hDEADBEEF);
        do_req(0, 1'b1, BASE + 1,  2'd0, 32'h0,        1'b0, got);
        chk("plan_byte_read", got, 32'h000000AD);
        do_req(0, 1'b1, BASE + 2,  2'd1, 32'h0,        1'b0, got);
        chk("plan_half_read", got, 32'h0000BEEF);
        do_req(0, 1'b0, BASE + 3,  2'd0, 32'hFFFFFF11, 1'b0, got);
        do_req(0, 1'b1, BASE,      2'd2, 32'h0,        1'b0, got);
        chk("plan_byte_merge", got, 32'hDEADBE11);
        do_req(0, 1'b1, BASE + 2,  2'd2, 32'h0,        1'b0, got);
        chk("plan_misaligned_hold", got, 32'hDEADBE11);
        do_req(0, 1'b1, 32'h8000_0000, 2'd2, 32'h0,    1'b0, got);
        chk("plan_range_hold", got, 32'hDEADBE11);

        // Window boundaries
        do_req(0, 1'b0, BASE + 32'hFFC,  2'd2, 32'hA5A55A5A, 1'b0, got);
        do_req(0, 1'b1, BASE + 32'hFFC,  2'd2, 32'h0,        1'b0, got);
        chk("plan_last_word", got, 32'hA5A55A5A);
        do_req(0, 1'b1, BASE + 32'h1000, 2'd2, 32'h0,        1'b0, got);

        // Latency 4 with an ignored enable mid-flight
        do_req(2, 1'b0, BASE + 8,  2'd2, 32'h0A0B0C0D, 1'b0, got);
        do_req(2, 1'b0, BASE + 12, 2'd2, 32'h11223344, 1'b0, got);
        do_req(2, 1'b1, BASE + 8,  2'd2, 32'h0,        1'b1, got);
        chk("plan_busy_ignore", got, 32'h0A0B0C0D);

        // Reset during the wait phase of a latency-3 write
        do_req(1, 1'b0, BASE + 16, 2'd2, 32'hCAFEF00D, 1'b0, got);
        en[1] = 1'b1; rw[1] = 1'b0; addr[1] = BASE + 16; sz[1] = 2'd2; din[1] = 32'h12345678;
        @(negedge clk);
        en[1] = 1'b0;
        chk("rst_mid_busy_before", 32'(busy[1]), 32'h1);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_busy_async", 32'(busy[1]), 32'h0);
        @(negedge clk);
        chk_reset_state("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        for (int u = 0; u < NU; u++) last_rd[u] = 32'h0;
        @(negedge clk);
        do_req(1, 1'b1, BASE + 16, 2'd2, 32'h0, 1'b0, got);
        chk("plan_write_abandoned", got, 32'hCAFEF00D);

        // Randomized traffic over a small initialised window plus illegal addresses
        for (int u = 0; u < NU; u++) begin
            for (int w = 0; w < 16; w++) do_req(u, 1'b0, BASE + 4 * w, 2'd2, $urandom, 1'b0, got);
            for (int t = 0; t < 40; t++) begin
                int r = $urandom_range(0, 9);
                if (r == 0)      a = BASE - 4 * $urandom_range(1, 4);
                else if (r == 1) a = BASE + 32'h1000 + $urandom_range(0, 15);
                else             a = BASE + $urandom_range(0, 63);
                do_req(u, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom, 1'b0, got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
